// File: rtl/hazard_ctrl.sv
// rtl/hazard_ctrl.sv - EX/MEM/WB hazard tracker: stall, flush, forwarding selects, stall counter
// Optional: define HAZARD_MEM_FWD_EN to forward load data straight from MEM (select 10).
module hazard_ctrl (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_hold,
    input  logic        i_id_valid,
    input  logic [4:0]  i_id_rs,
    input  logic [4:0]  i_id_rt,
    input  logic        i_id_uses_rs,
    input  logic        i_id_uses_rt,
    input  logic        i_id_wr_en,
    input  logic [4:0]  i_id_wr_addr,
    input  logic        i_id_is_load,
    input  logic        i_pcsrc,
    input  logic        i_cnt_clr,
    output logic [1:0]  o_mux_ctrl1,
    output logic [1:0]  o_mux_ctrl2,
    output logic        o_stall,
    output logic        o_flush,
    output logic [15:0] o_stall_cnt
);

    localparam logic [15:0] CNT_MAX = 16'hFFFF;

    localparam logic [1:0] SEL_RF  = 2'b00;
    localparam logic [1:0] SEL_ALU = 2'b01;
    localparam logic [1:0] SEL_MEM = 2'b10;
    localparam logic [1:0] SEL_WB  = 2'b11;

    logic       ex_valid_q,  ex_valid_d;
    logic       ex_wr_en_q,  ex_wr_en_d;
    logic [4:0] ex_addr_q,   ex_addr_d;
    logic       ex_load_q,   ex_load_d;

    logic       mem_valid_q, mem_valid_d;
    logic       mem_wr_en_q, mem_wr_en_d;
    logic [4:0] mem_addr_q,  mem_addr_d;
    logic       mem_load_q,  mem_load_d;

    logic       wb_valid_q,  wb_valid_d;
    logic       wb_wr_en_q,  wb_wr_en_d;
    logic [4:0] wb_addr_q,   wb_addr_d;

    logic [15:0] stall_cnt_q, stall_cnt_d;

    logic ex_hit_rs,  ex_hit_rt;
    logic mem_hit_rs, mem_hit_rt;
    logic wb_hit_rs,  wb_hit_rt;
    logic mem_load_block;
    logic stall_raw;

    // r0 is hardwired zero, so it never creates a dependency.
    function automatic logic op_match(input logic       valid,
                                      input logic       wr_en,
                                      input logic [4:0] addr,
                                      input logic [4:0] src,
                                      input logic       uses);
        return valid & wr_en & (addr == src) & (src != 5'd0) & uses;
    endfunction

    function automatic logic [1:0] fwd_sel(input logic mem_hit,
                                           input logic mem_load,
                                           input logic wb_hit);
        logic [1:0] sel;
        sel = SEL_RF;
`ifdef HAZARD_MEM_FWD_EN
        if (mem_hit) begin
            sel = mem_load ? SEL_MEM : SEL_ALU;
        end else if (wb_hit) begin
            sel = SEL_WB;
        end
`else
        if (mem_hit && !mem_load) begin
            sel = SEL_ALU;
        end else if (wb_hit) begin
            sel = SEL_WB;
        end
`endif
        return sel;
    endfunction

    assign ex_hit_rs  = op_match(ex_valid_q,  ex_wr_en_q,  ex_addr_q,  i_id_rs, i_id_uses_rs);
    assign ex_hit_rt  = op_match(ex_valid_q,  ex_wr_en_q,  ex_addr_q,  i_id_rt, i_id_uses_rt);
    assign mem_hit_rs = op_match(mem_valid_q, mem_wr_en_q, mem_addr_q, i_id_rs, i_id_uses_rs);
    assign mem_hit_rt = op_match(mem_valid_q, mem_wr_en_q, mem_addr_q, i_id_rt, i_id_uses_rt);
    assign wb_hit_rs  = op_match(wb_valid_q,  wb_wr_en_q,  wb_addr_q,  i_id_rs, i_id_uses_rs);
    assign wb_hit_rt  = op_match(wb_valid_q,  wb_wr_en_q,  wb_addr_q,  i_id_rt, i_id_uses_rt);

`ifdef HAZARD_MEM_FWD_EN
    assign mem_load_block = 1'b0;
`else
    // Without a MEM data path the consumer waits until the load reaches WB.
    assign mem_load_block = mem_load_q & (mem_hit_rs | mem_hit_rt);
`endif

    assign stall_raw = i_id_valid & (ex_hit_rs | ex_hit_rt | mem_load_block);

    assign o_stall     = stall_raw & ~i_hold & ~i_rst;
    assign o_flush     = i_pcsrc & i_id_valid & ~o_stall & ~i_hold & ~i_rst;
    assign o_mux_ctrl1 = fwd_sel(mem_hit_rs, mem_load_q, wb_hit_rs);
    assign o_mux_ctrl2 = fwd_sel(mem_hit_rt, mem_load_q, wb_hit_rt);
    assign o_stall_cnt = stall_cnt_q;

    always_comb begin
        ex_valid_d  = ex_valid_q;
        ex_wr_en_d  = ex_wr_en_q;
        ex_addr_d   = ex_addr_q;
        ex_load_d   = ex_load_q;
        mem_valid_d = mem_valid_q;
        mem_wr_en_d = mem_wr_en_q;
        mem_addr_d  = mem_addr_q;
        mem_load_d  = mem_load_q;
        wb_valid_d  = wb_valid_q;
        wb_wr_en_d  = wb_wr_en_q;
        wb_addr_d   = wb_addr_q;
        stall_cnt_d = stall_cnt_q;

        if (!i_hold) begin
            wb_valid_d  = mem_valid_q;
            wb_wr_en_d  = mem_wr_en_q;
            wb_addr_d   = mem_addr_q;
            mem_valid_d = ex_valid_q;
            mem_wr_en_d = ex_wr_en_q;
            mem_addr_d  = ex_addr_q;
            mem_load_d  = ex_load_q;
            // A stalled decode slot enters EX as a bubble.
            ex_valid_d  = i_id_valid & ~o_stall;
            ex_wr_en_d  = i_id_wr_en;
            ex_addr_d   = i_id_wr_addr;
            ex_load_d   = i_id_is_load;

            if (i_cnt_clr) begin
                stall_cnt_d = 16'd0;
            end else if (o_stall && (stall_cnt_q != CNT_MAX)) begin
                stall_cnt_d = stall_cnt_q + 16'd1;
            end
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            ex_valid_q  <= 1'b0;
            ex_wr_en_q  <= 1'b0;
            ex_addr_q   <= 5'd0;
            ex_load_q   <= 1'b0;
            mem_valid_q <= 1'b0;
            mem_wr_en_q <= 1'b0;
            mem_addr_q  <= 5'd0;
            mem_load_q  <= 1'b0;
            wb_valid_q  <= 1'b0;
            wb_wr_en_q  <= 1'b0;
            wb_addr_q   <= 5'd0;
            stall_cnt_q <= 16'd0;
        end else begin
            ex_valid_q  <= ex_valid_d;
            ex_wr_en_q  <= ex_wr_en_d;
            ex_addr_q   <= ex_addr_d;
            ex_load_q   <= ex_load_d;
            mem_valid_q <= mem_valid_d;
            mem_wr_en_q <= mem_wr_en_d;
            mem_addr_q  <= mem_addr_d;
            mem_load_q  <= mem_load_d;
            wb_valid_q  <= wb_valid_d;
            wb_wr_en_q  <= wb_wr_en_d;
            wb_addr_q   <= wb_addr_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb/tb_hazard_ctrl.sv - directed and randomized checks of hazard_ctrl against a pipeline-history model
module tb_hazard_ctrl;

`ifdef HAZARD_MEM_FWD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    logic        clk;
    logic        rst;
    logic        hold;
    logic        id_valid;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic        urs;
    logic        urt;
    logic        we;
    logic [4:0]  wa;
    logic        ld;
    logic        pcsrc;
    logic        clr;
    logic [1:0]  sel1;
    logic [1:0]  sel2;
    logic        stall;
    logic        flush;
    logic [15:0] cnt;

    hazard_ctrl dut (
        .i_clk        (clk),
        .i_rst        (rst),
        .i_hold       (hold),
        .i_id_valid   (id_valid),
        .i_id_rs      (rs),
        .i_id_rt      (rt),
        .i_id_uses_rs (urs),
        .i_id_uses_rt (urt),
        .i_id_wr_en   (we),
        .i_id_wr_addr (wa),
        .i_id_is_load (ld),
        .i_pcsrc      (pcsrc),
        .i_cnt_clr    (clr),
        .o_mux_ctrl1  (sel1),
        .o_mux_ctrl2  (sel2),
        .o_stall      (stall),
        .o_flush      (flush),
        .o_stall_cnt  (cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // History of the last three issued slots: 0 = EX, 1 = MEM, 2 = WB.
    bit        m_v  [3];
    bit        m_we [3];
    bit        m_ld [3];
    bit [4:0]  m_a  [3];
    int        m_cnt;

    int nchk;
    int nerr;

    logic [1:0]  obs_sel1;
    logic [1:0]  obs_sel2;
    logic        obs_stall;
    logic        obs_flush;
    logic [15:0] obs_cnt;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nchk++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic bit hit(input int s, input logic [4:0] x, input logic u);
        return m_v[s] && m_we[s] && (m_a[s] == x) && (x != 5'd0) && u;
    endfunction

    function automatic bit exp_stall();
        bit need;
        need = hit(0, rs, urs) || hit(0, rt, urt);
        if (!FWD && m_ld[1] && (hit(1, rs, urs) || hit(1, rt, urt)))
            need = 1'b1;
        return !rst && !hold && id_valid && need;
    endfunction

    // -1 marks a select the consumer cannot rely on.
    function automatic int exp_sel(input logic [4:0] x, input logic u);
        if (hit(1, x, u)) begin
            if (m_ld[1])
                return FWD ? 2 : -1;
            return 1;
        end
        if (hit(2, x, u))
            return 3;
        return 0;
    endfunction

    task automatic model_clear();
        for (int i = 0; i < 3; i++) begin
            m_v[i]  = 1'b0;
            m_we[i] = 1'b0;
            m_ld[i] = 1'b0;
            m_a[i]  = 5'd0;
        end
        m_cnt = 0;
    endtask

    // Starts and ends on a falling edge; one rising edge happens inside.
    task automatic cyc(input bit v, input logic [4:0] s, input logic [4:0] t,
                       input bit us, input bit ut, input bit w, input logic [4:0] a,
                       input bit l, input bit p, input bit h, input bit c);
        bit es;
        bit ef;
        int e1;
        int e2;
        id_valid = v; rs = s; rt = t; urs = us; urt = ut;
        we = w; wa = a; ld = l; pcsrc = p; hold = h; clr = c;
        #1;
        es = exp_stall();
        ef = p && v && !es && !h;
        e1 = exp_sel(s, us);
        e2 = exp_sel(t, ut);
        obs_sel1 = sel1; obs_sel2 = sel2; obs_stall = stall; obs_flush = flush; obs_cnt = cnt;
        chk("stall", stall, es);
        chk("flush", flush, ef);
        chk("cnt", cnt, m_cnt);
        if (!es && e1 >= 0) chk("sel1", sel1, e1);
        if (!es && e2 >= 0) chk("sel2", sel2, e2);
        if (!FWD) begin
            chk("sel1_no10", sel1 == 2'b10, 0);
            chk("sel2_no10", sel2 == 2'b10, 0);
        end
        @(posedge clk);
        if (!h) begin
            if (c)
                m_cnt = 0;
            else if (es && m_cnt != 65535)
                m_cnt++;
            for (int i = 2; i > 0; i--) begin
                m_v[i] = m_v[i-1]; m_we[i] = m_we[i-1]; m_ld[i] = m_ld[i-1]; m_a[i] = m_a[i-1];
            end
            m_v[0] = v && !es; m_we[0] = w; m_ld[0] = l; m_a[0] = a;
        end
        @(negedge clk);
    endtask

    task automatic rst_checks(input string tag);
        chk({tag, "_stall"}, stall, 0);
        chk({tag, "_flush"}, flush, 0);
        chk({tag, "_sel1"}, sel1, 0);
        chk({tag, "_sel2"}, sel2, 0);
        chk({tag, "_cnt"}, cnt, 0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        #1;
        model_clear();
        rst_checks("reset");
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        nchk = 0; nerr = 0;
        rst = 1'b0; hold = 1'b0; id_valid = 1'b1; rs = 5'd1; rt = 5'd1; urs = 1'b1; urt = 1'b1;
        we = 1'b0; wa = 5'd0; ld = 1'b0; pcsrc = 1'b1; clr = 1'b0;
        model_clear();
        @(negedge clk);
        do_reset();

        // add r3 ; beq r3,r4
        cyc(1, 5'd1, 5'd2, 1, 1, 1, 5'd3, 0, 0, 0, 0);
        chk("alu_first_nostall", obs_stall, 0);
        cyc(1, 5'd3, 5'd4, 1, 1, 0, 5'd0, 0, 0, 0, 0);
        chk("alu_use_stall", obs_stall, 1);
        cyc(1, 5'd3, 5'd4, 1, 1, 0, 5'd0, 0, 0, 0, 0);
        chk("alu_use_go", obs_stall, 0);
        chk("alu_use_sel1", obs_sel1, 2'b01);
        chk("alu_use_cnt", obs_cnt, 1);

        // lw r5 ; sub r6,r5,r7
        do_reset();
        cyc(1, 5'd1, 5'd0, 1, 0, 1, 5'd5, 1, 0, 0, 0);
        cyc(1, 5'd5, 5'd7, 1, 1, 1, 5'd6, 0, 0, 0, 0);
        chk("load_use_stall1", obs_stall, 1);
        if (FWD) begin
            cyc(1, 5'd5, 5'd7, 1, 1, 1, 5'd6, 0, 0, 0, 0);
            chk("load_use_go", obs_stall, 0);
            chk("load_use_sel1", obs_sel1, 2'b10);
        end else begin
            cyc(1, 5'd5, 5'd7, 1, 1, 1, 5'd6, 0, 0, 0, 0);
            chk("load_use_stall2", obs_stall, 1);
            cyc(1, 5'd5, 5'd7, 1, 1, 1, 5'd6, 0, 0, 0, 0);
            chk("load_use_go", obs_stall, 0);
            chk("load_use_sel1", obs_sel1, 2'b11);
            chk("load_use_cnt", obs_cnt, 2);
        end

        // MEM beats WB for r8; r0 never forwards
        do_reset();
        cyc(1, 5'd0, 5'd0, 0, 0, 1, 5'd8, 0, 0, 0, 0);
        cyc(1, 5'd0, 5'd0, 0, 0, 1, 5'd8, 0, 0, 0, 0);
        cyc(1, 5'd0, 5'd0, 0, 0, 1, 5'd9, 0, 0, 0, 0);
        cyc(1, 5'd0, 5'd8, 0, 1, 0, 5'd0, 0, 0, 0, 0);
        chk("prio_sel2", obs_sel2, 2'b01);
        chk("prio_nostall", obs_stall, 0);
        do_reset();
        cyc(1, 5'd0, 5'd0, 0, 0, 1, 5'd0, 0, 0, 0, 0);
        cyc(1, 5'd0, 5'd0, 1, 1, 0, 5'd0, 0, 0, 0, 0);
        chk("r0_nostall", obs_stall, 0);
        chk("r0_sel1", obs_sel1, 2'b00);
        chk("r0_sel2", obs_sel2, 2'b00);

        // taken branch, plain and under stall
        do_reset();
        cyc(1, 5'd0, 5'd0, 0, 0, 0, 5'd0, 0, 1, 0, 0);
        chk("flush_plain", obs_flush, 1);
        cyc(1, 5'd1, 5'd2, 1, 1, 1, 5'd3, 0, 0, 0, 0);
        chk("flush_one_cycle", obs_flush, 0);
        cyc(1, 5'd3, 5'd4, 1, 1, 0, 5'd0, 0, 1, 0, 0);
        chk("flush_under_stall", obs_flush, 0);
        chk("flush_stall", obs_stall, 1);
        cyc(1, 5'd3, 5'd4, 1, 1, 0, 5'd0, 0, 1, 0, 0);
        chk("flush_after_stall", obs_flush, 1);

        // hold during a load-use hazard
        do_reset();
        cyc(1, 5'd1, 5'd0, 1, 0, 1, 5'd5, 1, 0, 0, 0);
        for (int i = 0; i < 3; i++) begin
            cyc(1, 5'd5, 5'd7, 1, 1, 1, 5'd6, 0, 0, 1, 0);
            chk("hold_stall", obs_stall, 0);
            chk("hold_cnt", obs_cnt, 0);
        end
        cyc(1, 5'd5, 5'd7, 1, 1, 1, 5'd6, 0, 0, 0, 0);
        chk("hold_release_stall", obs_stall, 1);

        // counter saturation and clear
        do_reset();
        force dut.stall_cnt_q = 16'hFFFE;
        #1;
        release dut.stall_cnt_q;
        m_cnt = 16'hFFFE;
        for (int i = 0; i < 7; i++)
            cyc(1, 5'd3, 5'd0, 1, 0, 1, 5'd3, 0, 0, 0, 0);
        chk("cnt_saturate", obs_cnt, 16'hFFFF);
        cyc(1, 5'd3, 5'd0, 1, 0, 1, 5'd3, 0, 0, 0, 1);
        chk("clr_with_stall", obs_stall, 1);
        cyc(1, 5'd3, 5'd0, 1, 0, 1, 5'd3, 0, 0, 0, 0);
        chk("cnt_cleared", obs_cnt, 0);

        // reset mid-stall
        do_reset();
        cyc(1, 5'd0, 5'd0, 0, 0, 1, 5'd3, 0, 0, 0, 0);
        id_valid = 1; rs = 5'd3; urs = 1; urt = 0; we = 0; hold = 0; clr = 0; pcsrc = 1;
        #1;
        chk("pre_rst_stall", stall, 1);
        do_reset();

        // randomized traffic
        for (int n = 0; n < 400; n++) begin
            if ($urandom_range(0, 39) == 0) begin
                do_reset();
            end else begin
                cyc($urandom_range(0, 9) < 8,
                    5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                    $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1,
                    $urandom_range(0, 3) != 0, 5'($urandom_range(0, 3)),
                    $urandom_range(0, 2) == 0,
                    $urandom_range(0, 4) == 0,
                    $urandom_range(0, 7) == 0,
                    $urandom_range(0, 29) == 0);
            end
        end

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule
